// File: rtl/stepdown_delay_scheduler_if.sv
// Request/grant and delay-cell handshake bundle for stepdown_delay_scheduler.
// master = requesters plus the delay cell, slave = the scheduler.
interface stepdown_delay_scheduler_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] ack;
    logic [NREQ-1:0] err;
    logic [2:0]      gnt_id;
    logic            busy;
    logic            dly_i;
    logic            dly_o;

    modport master (
        output req, dly_o,
        input  ack, err, gnt_id, busy, dly_i
    );

    modport slave (
        input  req, dly_o,
        output ack, err, gnt_id, busy, dly_i
    );
endinterface

// File: rtl/stepdown_delay_scheduler.sv
// Round-robin sequencer sharing one rise-edge delay cell among NREQ requesters;
// returns ack on the delayed edge or err when the edge misses the window.
module stepdown_delay_scheduler #(
    parameter int NREQ       = 4,
    parameter int TMO_CYCLES = 32
) (
    input logic CELCLK,
    input logic CELRSTN,
    input logic CELV,
    input logic CELG,
    input logic CELSUB,
    stepdown_delay_scheduler_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ARM, WAIT_HI, DONE, FAIL, DRAIN} state_t;

    localparam logic [7:0] TMO_LAST = 8'(TMO_CYCLES - 1);

    state_t            state;
    logic [2:0]        rr;
    logic [7:0]        cnt;
    logic              sync_q;
    logic              dly_o_s;
    logic [2*NREQ-1:0] req_dbl;
    logic [NREQ-1:0]   req_rot;
    logic [2:0]        offset;
    logic              found;
    logic [3:0]        wsum;
    logic [2:0]        winner;
    logic [2:0]        rr_next;
    logic [NREQ-1:0]   gnt_onehot;
    logic              unused_supply;

    // Supply, ground and substrate pins carry no logic.
    assign unused_supply = CELV ^ CELG ^ CELSUB;

    always_ff @(posedge CELCLK or negedge CELRSTN) begin
        if (!CELRSTN) begin
            sync_q  <= 1'b0;
            dly_o_s <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make the two flops a real shift chain.
            sync_q  <= bus.dly_o;
            dly_o_s <= sync_q;
        end
    end

    // Rotate requests so index 0 is the rr pointer, pick the lowest set bit.
    assign req_dbl = {bus.req, bus.req};
    assign req_rot = NREQ'(req_dbl >> rr);

    always_comb begin
        // NOTE: defaults first so no path through the loop leaves these as latches.
        offset = 3'd0;
        found  = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req_rot[k]) begin
                offset = 3'(k);
                found  = 1'b1;
            end
        end
    end

    assign wsum       = {1'b0, rr} + {1'b0, offset};
    assign winner     = (wsum >= 4'(NREQ)) ? 3'(wsum - 4'(NREQ)) : 3'(wsum);
    assign rr_next    = (bus.gnt_id == 3'(NREQ - 1)) ? 3'd0 : bus.gnt_id + 3'd1;
    assign gnt_onehot = NREQ'(1) << bus.gnt_id;

    // Outputs are registered on entry to the state that owns them.
    always_ff @(posedge CELCLK or negedge CELRSTN) begin
        if (!CELRSTN) begin
            state      <= IDLE;
            rr         <= 3'd0;
            cnt        <= 8'd0;
            bus.gnt_id <= 3'd0;
            bus.busy   <= 1'b0;
            bus.dly_i  <= 1'b0;
            bus.ack    <= '0;
            bus.err    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|bus.req && !dly_o_s) begin
                        bus.gnt_id <= winner;
                        bus.busy   <= 1'b1;
                        state      <= ARM;
                    end
                end
                ARM: begin
                    bus.dly_i <= 1'b1;
                    cnt       <= 8'd0;
                    state     <= WAIT_HI;
                end
                WAIT_HI: begin
                    cnt <= cnt + 8'd1;
                    // A late edge arriving on the last window cycle still counts.
                    if (dly_o_s) begin
                        bus.ack   <= gnt_onehot;
                        bus.dly_i <= 1'b0;
                        rr        <= rr_next;
                        state     <= DONE;
                    end else if (cnt == TMO_LAST) begin
                        bus.err   <= gnt_onehot;
                        bus.dly_i <= 1'b0;
                        rr        <= rr_next;
                        state     <= FAIL;
                    end
                end
                DONE, FAIL: begin
                    bus.ack <= '0;
                    bus.err <= '0;
                    state   <= DRAIN;
                end
                DRAIN: begin
                    if (!dly_o_s) begin
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_stepdown_delay_scheduler.sv
// Scoreboard bench for stepdown_delay_scheduler with a cycle-based delay cell model.
module tb_stepdown_delay_scheduler;
    localparam int NREQ = 4;
    localparam int TMO  = 32;

    typedef enum {M_NORMAL, M_LOW, M_HIGH} mode_t;
    typedef struct { bit is_err; int id; } exp_t;
    typedef struct { bit is_err; int id; int c; logic dly_i; } obs_t;

    logic  clk = 1'b0;
    logic  rst_n;
    mode_t mode;
    int    delay_cyc;
    int    hi_cnt;
    int    cyc;
    int    n_run;
    int    n_fail;
    int    bad_pulse;
    int    arm_cyc;
    logic  busy_q;
    exp_t  exp_q[$];
    obs_t  obs_q[$];

    always #5 clk = ~clk;

    stepdown_delay_scheduler_if #(.NREQ(NREQ)) bus ();

    stepdown_delay_scheduler #(.NREQ(NREQ), .TMO_CYCLES(TMO)) dut (
        .CELCLK (clk),
        .CELRSTN(rst_n),
        .CELV   (1'b1),
        .CELG   (1'b0),
        .CELSUB (1'b0),
        .bus    (bus.slave)
    );

    // Delay cell: o rises delay_cyc negedges after i rises, falls when i is low.
    always @(negedge clk) begin
        if (mode == M_LOW) begin
            bus.dly_o = 1'b0;
        end else if (mode == M_HIGH) begin
            bus.dly_o = 1'b1;
        end else if (bus.dly_i !== 1'b1) begin
            hi_cnt    = 0;
            bus.dly_o = 1'b0;
        end else begin
            hi_cnt = hi_cnt + 1;
            if (hi_cnt >= delay_cyc) bus.dly_o = 1'b1;
        end
    end

    always @(posedge clk) cyc = cyc + 1;

    function automatic int onehot_idx(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) if (v[i] === 1'b1) return i;
        return -1;
    endfunction

    function automatic string kind(input bit is_err);
        return is_err ? "err" : "ack";
    endfunction

    // Monitor: records every ack/err pulse and any illegal pulse pattern.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (bus.busy === 1'b1 && busy_q !== 1'b1) arm_cyc = cyc;
            busy_q = bus.busy;
            if (!$onehot0(bus.ack) || !$onehot0(bus.err) || (|bus.ack && |bus.err))
                bad_pulse = bad_pulse + 1;
            if (|bus.err)
                obs_q.push_back('{1'b1, onehot_idx(bus.err), cyc, bus.dly_i});
            else if (|bus.ack)
                obs_q.push_back('{1'b0, onehot_idx(bus.ack), cyc, bus.dly_i});
        end else begin
            busy_q = 1'b0;
        end
    end

    task automatic wait_obs(input int budget, output bit got);
        got = (obs_q.size() > 0);
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk); #1;
            got = (obs_q.size() > 0);
        end
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = (bus.busy === 1'b0);
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk); #1;
            ok = (bus.busy === 1'b0);
        end
    endtask

    task automatic apply_reset();
        rst_n   = 1'b0;
        bus.req = '0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        exp_q.delete();
        obs_q.delete();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_run++;
        if ({bus.ack, bus.err, bus.busy, bus.dly_i} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: ack=%b err=%b busy=%b dly_i=%b, want all 0",
                     bus.ack, bus.err, bus.busy, bus.dly_i);
        end
        n_run++;
        if (bus.gnt_id !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_gnt_id: got %0d, want 0", bus.gnt_id);
        end
        @(negedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        bit   got;
        obs_t o;
        exp_t e;
        int   rise_c;
        @(negedge clk); #1;
        bus.req[2] = 1'b1;
        exp_q.push_back('{1'b0, 2});
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk); #1;
            got = (bus.busy === 1'b1);
        end
        n_run++;
        if (!got) begin
            n_fail++;
            $display("FAIL single_grant: busy=%b after 8 cycles, want 1", bus.busy);
        end
        n_run++;
        if (bus.dly_i !== 1'b0) begin
            n_fail++;
            $display("FAIL single_arm_dly_i: got %b in ARM, want 0", bus.dly_i);
        end
        @(negedge clk); #1;
        rise_c = cyc;
        n_run++;
        if (bus.dly_i !== 1'b1) begin
            n_fail++;
            $display("FAIL single_dly_i_rise: got %b after ARM, want 1", bus.dly_i);
        end
        wait_obs(40, got);
        n_run++;
        if (!got) begin
            n_fail++;
            $display("FAIL single_ack: no pulse within 40 cycles, want ack[2]");
        end else begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            if (o.is_err !== e.is_err || o.id !== e.id) begin
                n_fail++;
                $display("FAIL single_ack: got %s[%0d], want %s[%0d]",
                         kind(o.is_err), o.id, kind(e.is_err), e.id);
            end
            n_run++;
            if (o.c - rise_c !== 13) begin
                n_fail++;
                $display("FAIL single_latency: ack %0d cycles after dly_i rise, want 13",
                         o.c - rise_c);
            end
        end
        bus.req[2] = 1'b0;
        @(negedge clk); #1;
        n_run++;
        if (bus.ack !== '0) begin
            n_fail++;
            $display("FAIL single_pulse_width: ack=%b one cycle later, want 0", bus.ack);
        end
        wait_idle(20, got);
        n_run++;
        if (!got || bus.gnt_id !== 3'd2) begin
            n_fail++;
            $display("FAIL single_idle: busy=%b gnt_id=%0d, want busy=0 gnt_id=2",
                     bus.busy, bus.gnt_id);
        end
    endtask

    task automatic test_round_robin();
        bit   got;
        obs_t o;
        exp_t e;
        apply_reset();
        @(negedge clk); #1;
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) exp_q.push_back('{1'b0, k % NREQ});
        for (int k = 0; k < 5; k++) begin
            wait_obs(100, got);
            n_run++;
            if (!got) begin
                n_fail++;
                $display("FAIL rr_order_%0d: no pulse within 100 cycles", k);
            end else begin
                o = obs_q.pop_front();
                e = exp_q.pop_front();
                if (o.is_err !== e.is_err || o.id !== e.id) begin
                    n_fail++;
                    $display("FAIL rr_order_%0d: got %s[%0d], want %s[%0d]",
                             k, kind(o.is_err), o.id, kind(e.is_err), e.id);
                end
                if (o.id >= 0) begin
                    bus.req = bus.req & ~(NREQ'(1) << o.id);
                    @(negedge clk); #1;
                    if (k < 4) bus.req = bus.req | (NREQ'(1) << o.id);
                end
            end
        end
        bus.req = '0;
        wait_idle(20, got);
        n_run++;
        if (bad_pulse !== 0) begin
            n_fail++;
            $display("FAIL rr_onehot: %0d cycles with overlapping pulses, want 0", bad_pulse);
        end
    endtask

    task automatic test_timeout();
        bit   got;
        obs_t o;
        exp_t e;
        mode = M_LOW;
        @(negedge clk); #1;
        bus.req[1] = 1'b1;
        exp_q.push_back('{1'b1, 1});
        wait_obs(100, got);
        n_run++;
        if (!got) begin
            n_fail++;
            $display("FAIL timeout_err: no pulse within 100 cycles, want err[1]");
        end else begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            if (o.is_err !== e.is_err || o.id !== e.id) begin
                n_fail++;
                $display("FAIL timeout_err: got %s[%0d], want %s[%0d]",
                         kind(o.is_err), o.id, kind(e.is_err), e.id);
            end
            n_run++;
            if (o.c - arm_cyc !== TMO + 1 || o.dly_i !== 1'b0) begin
                n_fail++;
                $display("FAIL timeout_timing: err %0d cycles after ARM dly_i=%b, want %0d and 0",
                         o.c - arm_cyc, o.dly_i, TMO + 1);
            end
        end
        bus.req[1] = 1'b0;
        mode = M_NORMAL;
        wait_idle(20, got);
        @(negedge clk); #1;
        bus.req = 4'b0101;
        exp_q.push_back('{1'b0, 2});
        exp_q.push_back('{1'b0, 0});
        for (int k = 0; k < 2; k++) begin
            wait_obs(100, got);
            n_run++;
            if (!got) begin
                n_fail++;
                $display("FAIL timeout_next_%0d: no pulse within 100 cycles", k);
            end else begin
                o = obs_q.pop_front();
                e = exp_q.pop_front();
                if (o.is_err !== e.is_err || o.id !== e.id) begin
                    n_fail++;
                    $display("FAIL timeout_next_%0d: got %s[%0d], want %s[%0d]",
                             k, kind(o.is_err), o.id, kind(e.is_err), e.id);
                end
                if (o.id >= 0) bus.req = bus.req & ~(NREQ'(1) << o.id);
            end
        end
        wait_idle(20, got);
    endtask

    task automatic test_stuck();
        bit   got;
        obs_t o;
        exp_t e;
        mode = M_HIGH;
        repeat (4) @(negedge clk);
        #1;
        bus.req[0] = 1'b1;
        exp_q.push_back('{1'b0, 0});
        repeat (6) @(negedge clk);
        #1;
        n_run++;
        if (bus.busy !== 1'b0 || bus.dly_i !== 1'b0) begin
            n_fail++;
            $display("FAIL stuck_hold: busy=%b dly_i=%b, want 0 and 0", bus.busy, bus.dly_i);
        end
        mode = M_NORMAL;
        @(negedge clk);
        repeat (2) @(negedge clk);
        #1;
        n_run++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL stuck_early_grant: busy=%b two cycles after release, want 0", bus.busy);
        end
        @(negedge clk); #1;
        n_run++;
        if (bus.busy !== 1'b1 || bus.gnt_id !== 3'd0) begin
            n_fail++;
            $display("FAIL stuck_release_grant: busy=%b gnt_id=%0d, want 1 and 0",
                     bus.busy, bus.gnt_id);
        end
        wait_obs(40, got);
        n_run++;
        if (!got) begin
            n_fail++;
            $display("FAIL stuck_ack: no pulse within 40 cycles, want ack[0]");
        end else begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            if (o.is_err !== e.is_err || o.id !== e.id) begin
                n_fail++;
                $display("FAIL stuck_ack: got %s[%0d], want %s[%0d]",
                         kind(o.is_err), o.id, kind(e.is_err), e.id);
            end
        end
        bus.req[0] = 1'b0;
        wait_idle(20, got);
    endtask

    task automatic test_reset_mid();
        bit   got;
        obs_t o;
        exp_t e;
        @(negedge clk); #1;
        bus.req[3] = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk); #1;
            got = (bus.dly_i === 1'b1);
        end
        repeat (3) @(negedge clk);
        #1;
        n_run++;
        if (!got || bus.gnt_id !== 3'd3) begin
            n_fail++;
            $display("FAIL rstmid_setup: dly_i=%b gnt_id=%0d, want 1 and 3", bus.dly_i, bus.gnt_id);
        end
        rst_n = 1'b0;
        #1;
        n_run++;
        if (bus.dly_i !== 1'b0 || bus.busy !== 1'b0 || bus.gnt_id !== 3'd0) begin
            n_fail++;
            $display("FAIL rstmid_async: dly_i=%b busy=%b gnt_id=%0d, want 0 0 0",
                     bus.dly_i, bus.busy, bus.gnt_id);
        end
        bus.req[0] = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        exp_q.delete();
        obs_q.delete();
        rst_n = 1'b1;
        exp_q.push_back('{1'b0, 0});
        exp_q.push_back('{1'b0, 3});
        for (int k = 0; k < 2; k++) begin
            wait_obs(100, got);
            n_run++;
            if (!got) begin
                n_fail++;
                $display("FAIL rstmid_order_%0d: no pulse within 100 cycles", k);
            end else begin
                o = obs_q.pop_front();
                e = exp_q.pop_front();
                if (o.is_err !== e.is_err || o.id !== e.id) begin
                    n_fail++;
                    $display("FAIL rstmid_order_%0d: got %s[%0d], want %s[%0d]",
                             k, kind(o.is_err), o.id, kind(e.is_err), e.id);
                end
                if (o.id >= 0) bus.req = bus.req & ~(NREQ'(1) << o.id);
            end
        end
        wait_idle(20, got);
    endtask

    // Edge seen on the last window cycle (ack) versus one cycle later (err).
    task automatic test_simultaneous();
        bit   got;
        obs_t o;
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            delay_cyc = 30 + k;
            @(negedge clk); #1;
            bus.req[1] = 1'b1;
            exp_q.push_back('{k == 1, 1});
            wait_obs(100, got);
            n_run++;
            if (!got) begin
                n_fail++;
                $display("FAIL simul_%0d: no pulse within 100 cycles", delay_cyc);
            end else begin
                o = obs_q.pop_front();
                e = exp_q.pop_front();
                if (o.is_err !== e.is_err || o.id !== e.id || o.c - arm_cyc !== TMO + 1) begin
                    n_fail++;
                    $display("FAIL simul_%0d: got %s[%0d] at +%0d, want %s[%0d] at +%0d",
                             delay_cyc, kind(o.is_err), o.id, o.c - arm_cyc,
                             kind(e.is_err), e.id, TMO + 1);
                end
            end
            bus.req[1] = 1'b0;
            wait_idle(20, got);
        end
        delay_cyc = 11;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_run     = 0;
        n_fail    = 0;
        bad_pulse = 0;
        cyc       = 0;
        arm_cyc   = 0;
        hi_cnt    = 0;
        busy_q    = 1'b0;
        mode      = M_NORMAL;
        delay_cyc = 11;
        rst_n     = 1'b0;
        bus.req   = '0;

        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_stuck();
        test_reset_mid();
        test_simultaneous();

        n_run++;
        if (bad_pulse !== 0 || exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL final_state: bad_pulse=%0d pending=%0d, want 0 and 0",
                     bad_pulse, exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
